// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, PC increment and byte-merge helper for regfile_sb
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int PC_INC         = 4;
  // Widest DATA_W that byte_merge can serve; callers widen on entry and narrow on exit.
  localparam int MERGE_MAX_W    = 256;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_v,
    input logic [MERGE_MAX_W-1:0]   new_v,
    input logic [MERGE_MAX_W/8-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_v;
    for (int i = 0; i < MERGE_MAX_W/8; i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_sb_pc_unit.sv
// rtl/regfile_sb_pc_unit.sv - program counter register with branch / writeback / increment priority
module pc_unit
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_en,
  input  logic [DATA_W-1:0] br_target,
  input  logic              pc_wr_en,
  input  logic [DATA_W-1:0] pc_wr_data,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus4
);

  logic [DATA_W-1:0] pc_q, pc_d;

  assign pc_plus4 = pc_q + DATA_W'(PC_INC);
  assign pc       = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (br_en)         pc_d = br_target;
    else if (pc_wr_en) pc_d = pc_wr_data;
    else if (!stall)   pc_d = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with PC, byte-enable writes, branch-and-link and busy scoreboard
// REGFILE_BYPASS_EN: when defined, same-cycle reads see the pending write/link data.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int PC_IDX = 2**ADDR_W-1,
  parameter int LR_IDX = 2**ADDR_W-2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr,
  input  logic                     stall,
  input  logic                     br_en,
  input  logic [DATA_W-1:0]        br_target,
  input  logic                     br_link,
  output logic [DATA_W-1:0]        pc_out
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q    [NREG];
  logic [DATA_W-1:0] regs_d    [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [DATA_W-1:0] rd_data_d [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_q, rd_busy_d;
  logic [DATA_W-1:0] pc, pc_plus4;
  logic              pc_wr, link_wr;

  assign pc_wr   = wr_en && (wr_addr == ADDR_W'(PC_IDX));
  assign link_wr = br_en && br_link;

  pc_unit #(.DATA_W(DATA_W)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_en      (br_en),
    .br_target  (br_target),
    .pc_wr_en   (pc_wr),
    .pc_wr_data (wr_data),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  // The PC_IDX slot is never written, so it stays zero and never busy.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      if (i != PC_IDX) begin
        if (link_wr && i == LR_IDX)
          regs_d[i] = pc_plus4;
        else if (wr_en && wr_addr == ADDR_W'(i))
          regs_d[i] = DATA_W'(byte_merge(MERGE_MAX_W'(regs_q[i]), MERGE_MAX_W'(wr_data),
                                         (MERGE_MAX_W/8)'(wr_be)));
        if (wr_en && wr_addr == ADDR_W'(i))     busy_d[i] = 1'b0;
        if (resv_en && resv_addr == ADDR_W'(i)) busy_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_d[k] = '0;
      rd_busy_d[k] = busy_d[rd_addr[k*ADDR_W +: ADDR_W]];
      if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(PC_IDX))
        rd_data_d[k] = pc;
      else
`ifdef REGFILE_BYPASS_EN
        rd_data_d[k] = regs_d[rd_addr[k*ADDR_W +: ADDR_W]];
`else
        rd_data_d[k] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      for (int k = 0; k < NUM_RD; k++) rd_data_q[k] <= '0;
      busy_q    <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      for (int k = 0; k < NUM_RD; k++) rd_data_q[k] <= rd_data_d[k];
      busy_q    <= busy_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_out
    assign rd_data[k*DATA_W +: DATA_W] = rd_data_q[k];
  end

  assign rd_busy = rd_busy_q;
  assign pc_out  = pc;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and randomized bench for regfile_sb with a behavioural model
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        resv_en = 1'b0;
  logic [3:0]  resv_addr = '0;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = '0;
  logic        br_link = 1'b0;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .resv_en(resv_en), .resv_addr(resv_addr), .stall(stall), .br_en(br_en),
    .br_target(br_target), .br_link(br_link), .pc_out(pc_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_reg [16];
  logic        m_busy [16];
  logic [31:0] m_pc;
  logic [31:0] e_data [2];
  logic        e_busy [2];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_pc = '0;
    for (int k = 0; k < 2; k++) begin
      e_data[k] = '0;
      e_busy[k] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; resv_en = 1'b0; br_en = 1'b0; br_link = 1'b0;
    wr_be = '0; wr_data = '0; wr_addr = '0; resv_addr = '0; br_target = '0;
  endtask

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic cycle();
    logic [31:0] nxt [16];
    logic [3:0]  a;
    for (int i = 0; i < 16; i++) nxt[i] = m_reg[i];
    if (wr_en && wr_addr != 4'd15 && !(br_en && br_link && wr_addr == 4'd14))
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) nxt[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
    if (br_en && br_link) nxt[14] = m_pc + 32'd4;
    if (wr_en && wr_addr != 4'd15) m_busy[wr_addr] = 1'b0;
    if (resv_en && resv_addr != 4'd15) m_busy[resv_addr] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[4*k +: 4];
      if (a == 4'd15) e_data[k] = m_pc;
      else            e_data[k] = BYP ? nxt[a] : m_reg[a];
      e_busy[k] = m_busy[a];
    end
    if (br_en)                           m_pc = br_target;
    else if (wr_en && wr_addr == 4'd15)  m_pc = wr_data;
    else if (!stall)                     m_pc = m_pc + 32'd4;
    for (int i = 0; i < 16; i++) m_reg[i] = nxt[i];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); stall = 1'b0; rst_n = 1'b0; rd_addr = {4'd1, 4'd0};
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); end
    n_cmp++; if (rd_data !== 64'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want %h", rd_data, 64'h0); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_rd_busy: got %b want %b", rd_busy, 2'b00); end
    rst_n = 1'b1;
    model_reset();
    cycle();
    n_cmp++; if (pc_out !== 32'h4) begin n_err++; $display("FAIL incr_pc1: got %h want %h", pc_out, 32'h4); end
    cycle();
    n_cmp++; if (pc_out !== 32'h8) begin n_err++; $display("FAIL incr_pc2: got %h want %h", pc_out, 32'h8); end
    n_cmp++; if (rd_data !== 64'h0) begin n_err++; $display("FAIL incr_rd_data: got %h want %h", rd_data, 64'h0); end
  endtask

  task automatic test_byte_write();
    idle(); stall = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hAABBCCDD; wr_be = 4'b1111;
    cycle();
    wr_data = 32'h00000011; wr_be = 4'b0001;
    cycle();
    idle(); rd_addr = {4'd0, 4'd3};
    cycle();
    n_cmp++; if (rd_data[31:0] !== 32'hAABBCC11) begin n_err++; $display("FAIL byte_write: got %h want %h", rd_data[31:0], 32'hAABBCC11); end
  endtask

  task automatic test_branch_link();
    idle(); stall = 1'b1;
    br_en = 1'b1; br_target = 32'h20;
    cycle();
    n_cmp++; if (pc_out !== 32'h20) begin n_err++; $display("FAIL bl_setup_pc: got %h want %h", pc_out, 32'h20); end
    br_en = 1'b1; br_link = 1'b1; br_target = 32'h100;
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
    rd_addr = {4'd0, 4'd0};
    cycle();
    n_cmp++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL bl_pc: got %h want %h", pc_out, 32'h100); end
    idle(); rd_addr = {4'd14, 4'd15};
    cycle();
    n_cmp++; if (rd_data[63:32] !== 32'h24) begin n_err++; $display("FAIL bl_link_reg: got %h want %h", rd_data[63:32], 32'h24); end
    n_cmp++; if (rd_data[31:0] !== 32'h100) begin n_err++; $display("FAIL bl_read_pc: got %h want %h", rd_data[31:0], 32'h100); end
  endtask

  task automatic test_scoreboard();
    idle(); stall = 1'b1; rd_addr = {4'd15, 4'd5};
    resv_en = 1'b1; resv_addr = 4'd5;
    cycle();
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sb_resv: got %b want %b", rd_busy[0], 1'b1); end
    idle();
    cycle();
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sb_hold: got %b want %b", rd_busy[0], 1'b1); end
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h55; wr_be = 4'b1111;
    cycle();
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL sb_clear: got %b want %b", rd_busy[0], 1'b0); end
    resv_en = 1'b1; resv_addr = 4'd5;
    cycle();
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sb_resv_wins: got %b want %b", rd_busy[0], 1'b1); end
    resv_en = 1'b1; resv_addr = 4'd15; wr_be = 4'b0100;
    cycle();
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL sb_partial_and_pc: got %b want %b", rd_busy, 2'b00); end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    idle(); stall = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h5555; wr_be = 4'b1111;
    cycle();
    wr_data = 32'h1234; rd_addr = {4'd0, 4'd2};
    cycle();
    want = BYP ? 32'h1234 : 32'h5555;
    n_cmp++; if (rd_data[31:0] !== want) begin n_err++; $display("FAIL bypass_same_cycle: got %h want %h", rd_data[31:0], want); end
    idle();
    cycle();
    n_cmp++; if (rd_data[31:0] !== 32'h1234) begin n_err++; $display("FAIL bypass_next_cycle: got %h want %h", rd_data[31:0], 32'h1234); end
  endtask

  task automatic test_stall_pc_write();
    logic [31:0] held;
    idle(); stall = 1'b1;
    held = m_pc;
    repeat (2) cycle();
    n_cmp++; if (pc_out !== held) begin n_err++; $display("FAIL stall_hold: got %h want %h", pc_out, held); end
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h80; wr_be = 4'b0000;
    br_en = 1'b1; br_target = 32'h40;
    cycle();
    n_cmp++; if (pc_out !== 32'h40) begin n_err++; $display("FAIL br_over_pcwr: got %h want %h", pc_out, 32'h40); end
    br_en = 1'b0;
    cycle();
    n_cmp++; if (pc_out !== 32'h80) begin n_err++; $display("FAIL pc_write: got %h want %h", pc_out, 32'h80); end
    idle(); stall = 1'b0;
    cycle();
    n_cmp++; if (pc_out !== 32'h84) begin n_err++; $display("FAIL pc_resume: got %h want %h", pc_out, 32'h84); end
  endtask

  task automatic test_random(input int n);
    for (int it = 0; it < n; it++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 4'($urandom_range(0, 15));
      wr_be     = 4'($urandom_range(1, 15));
      wr_data   = $urandom;
      resv_en   = ($urandom_range(0, 3) == 0);
      resv_addr = 4'($urandom_range(0, 15));
      stall     = 1'($urandom_range(0, 1));
      br_en     = ($urandom_range(0, 7) == 0);
      br_target = $urandom;
      br_link   = 1'($urandom_range(0, 1));
      rd_addr   = 8'($urandom);
      if (br_en && br_link && wr_addr == 4'd14) wr_addr = 4'd13;
      cycle();
      n_cmp++; if (pc_out !== m_pc) begin n_err++; $display("FAIL rand_pc it=%0d: got %h want %h", it, pc_out, m_pc); end
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (rd_data[32*k +: 32] !== e_data[k]) begin n_err++; $display("FAIL rand_rd_data%0d it=%0d: got %h want %h", k, it, rd_data[32*k +: 32], e_data[k]); end
        n_cmp++; if (rd_busy[k] !== e_busy[k]) begin n_err++; $display("FAIL rand_rd_busy%0d it=%0d: got %b want %b", k, it, rd_busy[k], e_busy[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL midreset_pc: got %h want %h", pc_out, 32'h0); end
    n_cmp++; if (rd_data !== 64'h0) begin n_err++; $display("FAIL midreset_rd_data: got %h want %h", rd_data, 64'h0); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL midreset_rd_busy: got %b want %b", rd_busy, 2'b00); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_byte_write();
    test_branch_link();
    test_scoreboard();
    test_bypass();
    test_stall_pc_write();
    test_random(300);
    test_reset_mid();
    test_random(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
